// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/ALU encodings and FSM state type for the CPU control path.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_NOP = 0;
  localparam int unsigned OPC_ADD = 1;
  localparam int unsigned OPC_SUB = 2;
  localparam int unsigned OPC_AND = 3;
  localparam int unsigned OPC_OR  = 4;
  localparam int unsigned OPC_LW  = 5;
  localparam int unsigned OPC_SW  = 6;
  localparam int unsigned OPC_XOR = 7;
  // Becomes all-ones once cast to the opcode width, whatever that width is.
  localparam int          OPC_HALT = -1;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;
  localparam int unsigned ALU_XOR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; shared with the single-cycle decoder.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPC_W-1:0]    opcode_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                is_alu_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                is_halt_o,
  output logic                is_illegal_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_op_o     = '0;
    is_alu_o     = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    if (opcode_i == OPC_W'(OPC_HALT)) begin
      is_halt_o = 1'b1;
    end else begin
      case (opcode_i)
        OPC_W'(OPC_NOP): ;
        OPC_W'(OPC_ADD): begin is_alu_o = 1'b1; alu_op_o = ALU_OP_W'(ALU_ADD); end
        OPC_W'(OPC_SUB): begin is_alu_o = 1'b1; alu_op_o = ALU_OP_W'(ALU_SUB); end
        OPC_W'(OPC_AND): begin is_alu_o = 1'b1; alu_op_o = ALU_OP_W'(ALU_AND); end
        OPC_W'(OPC_OR):  begin is_alu_o = 1'b1; alu_op_o = ALU_OP_W'(ALU_OR);  end
        OPC_W'(OPC_XOR): begin is_alu_o = 1'b1; alu_op_o = ALU_OP_W'(ALU_XOR); end
        OPC_W'(OPC_LW):  begin is_load_o  = 1'b1; alu_op_o = ALU_OP_W'(ALU_ADD); end
        OPC_W'(OPC_SW):  begin is_store_o = 1'b1; alu_op_o = ALU_OP_W'(ALU_ADD); end
        default:         is_illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: latches one instruction per handshake and walks it
// through decode/execute/memory/writeback with registered datapath strobes.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int OPC_W       = 4,
  parameter int REG_AW      = 4,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic                instr_ready,
  input  logic                mem_ack,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [REG_AW-1:0]   write_reg,
  output logic                illegal,
  output logic                mem_timeout,
  output logic                halted
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q;
  logic [OPC_W-1:0]    opc_q;
  logic [REG_AW-1:0]   dest_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                instr_ready_q, mem_read_q, mem_write_q, reg_write_q;
  logic                illegal_q, mem_timeout_q, halted_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic [REG_AW-1:0]   write_reg_q;

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic dec_is_alu, dec_is_load, dec_is_store, dec_is_halt, dec_is_illegal;

  ctrl_decode #(.OPC_W(OPC_W), .ALU_OP_W(ALU_OP_W)) u_decode (
    .opcode_i     (opc_q),
    .alu_op_o     (dec_alu_op),
    .is_alu_o     (dec_is_alu),
    .is_load_o    (dec_is_load),
    .is_store_o   (dec_is_store),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

  // Only the opcode and destination fields are ever used by this unit.
  if (INSTR_W > OPC_W + REG_AW) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^instr[INSTR_W-OPC_W-REG_AW-1:0];
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      opc_q         <= '0;
      dest_q        <= '0;
      cnt_q         <= '0;
      instr_ready_q <= 1'b1;
      alu_op_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      write_reg_q   <= '0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge register values.
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && instr_ready_q) begin
            opc_q         <= instr[INSTR_W-1 -: OPC_W];
            dest_q        <= instr[INSTR_W-OPC_W-1 -: REG_AW];
            instr_ready_q <= 1'b0;
            state_q       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_is_halt) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else if (dec_is_alu || dec_is_load || dec_is_store) begin
            alu_op_q <= dec_alu_op;
            state_q  <= ST_EXEC;
          end else begin
            illegal_q     <= dec_is_illegal;
            instr_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (dec_is_load || dec_is_store) begin
            mem_read_q  <= dec_is_load;
            mem_write_q <= dec_is_store;
            cnt_q       <= '0;
            state_q     <= ST_MEM;
          end else begin
            reg_write_q <= 1'b1;
            write_reg_q <= dest_q;
            state_q     <= ST_WB;
          end
        end
        ST_MEM: begin
          // An ack arriving on the final allowed cycle still completes the access.
          if (mem_ack) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (dec_is_load) begin
              reg_write_q <= 1'b1;
              write_reg_q <= dest_q;
              state_q     <= ST_WB;
            end else begin
              alu_op_q      <= '0;
              instr_ready_q <= 1'b1;
              state_q       <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
              mem_read_q    <= 1'b0;
              mem_write_q   <= 1'b0;
              mem_timeout_q <= 1'b1;
              alu_op_q      <= '0;
              instr_ready_q <= 1'b1;
              state_q       <= ST_IDLE;
            end
          end
        end
        ST_WB: begin
          reg_write_q   <= 1'b0;
          write_reg_q   <= '0;
          alu_op_q      <= '0;
          instr_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        ST_HALT: ;
        default: begin
          instr_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_op      = alu_op_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign reg_write   = reg_write_q;
  assign write_reg   = write_reg_q;
  assign illegal     = illegal_q;
  assign mem_timeout = mem_timeout_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected output timelines built from the
// phase/latency rules, compared cycle by cycle under randomized stimulus.
module tb_multicycle_control_unit;

  localparam int T = 4;

  typedef struct packed {
    logic       ready;
    logic [3:0] alu;
    logic       rd;
    logic       wr;
    logic       rw;
    logic [3:0] wreg;
    logic       ill;
    logic       to;
    logic       halted;
  } obs_t;

  localparam int K_NOP = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_HALT = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        mem_ack;
  logic [3:0]  alu_op;
  logic        mem_read, mem_write, reg_write;
  logic [3:0]  write_reg;
  logic        illegal, mem_timeout, halted;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t obs;
  obs_t exp_q[$];
  bit   mem_q[$];

  assign obs = {instr_ready, alu_op, mem_read, mem_write, reg_write, write_reg,
                illegal, mem_timeout, halted};

  multicycle_control_unit #(
    .INSTR_W(16), .OPC_W(4), .REG_AW(4), .ALU_OP_W(4), .MEM_TIMEOUT(T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .mem_ack     (mem_ack),
    .alu_op      (alu_op),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .illegal     (illegal),
    .mem_timeout (mem_timeout),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("rdy=%0b alu=%0h rd=%0b wr=%0b rw=%0b wreg=%0h ill=%0b to=%0b halt=%0b",
                     o.ready, o.alu, o.rd, o.wr, o.rw, o.wreg, o.ill, o.to, o.halted);
  endfunction

  function automatic int ref_kind(input logic [3:0] opc);
    case (opc)
      4'd0:                               return K_NOP;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd7:       return K_ALU;
      4'd5:                               return K_LW;
      4'd6:                               return K_SW;
      4'd15:                              return K_HALT;
      default:                            return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input logic [3:0] opc);
    case (opc)
      4'd2:    return 4'd1;
      4'd3:    return 4'd2;
      4'd4:    return 4'd3;
      4'd7:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // Expected outputs for cycles 1..N after the handshake edge; last entry is
  // the first cycle back in IDLE. k = MEM cycle carrying mem_ack (1..T), else none.
  task automatic build_trace(input logic [15:0] w, input int k);
    int         kind;
    logic [3:0] code;
    int         m;
    bit         acked;
    obs_t       o, idle;
    exp_q.delete();
    mem_q.delete();
    kind  = ref_kind(w[15:12]);
    code  = ref_alu(w[15:12]);
    idle  = '0;
    idle.ready = 1'b1;
    o = '0;
    exp_q.push_back(o); mem_q.push_back(1'b0);
    case (kind)
      K_NOP: begin exp_q.push_back(idle); mem_q.push_back(1'b0); end
      K_ILL: begin o = idle; o.ill = 1'b1; exp_q.push_back(o); mem_q.push_back(1'b0); end
      K_HALT: begin o = '0; o.halted = 1'b1; exp_q.push_back(o); mem_q.push_back(1'b0); end
      K_ALU: begin
        o.alu = code;                      exp_q.push_back(o); mem_q.push_back(1'b0);
        o.rw = 1'b1; o.wreg = w[11:8];     exp_q.push_back(o); mem_q.push_back(1'b0);
        exp_q.push_back(idle); mem_q.push_back(1'b0);
      end
      default: begin
        acked = (k >= 1 && k <= T);
        m = acked ? k : T;
        o.alu = code; exp_q.push_back(o); mem_q.push_back(1'b0);
        o.rd = (kind == K_LW);
        o.wr = (kind == K_SW);
        for (int i = 0; i < m; i++) begin exp_q.push_back(o); mem_q.push_back(1'b1); end
        if (acked && kind == K_LW) begin
          o = '0; o.alu = code; o.rw = 1'b1; o.wreg = w[11:8];
          exp_q.push_back(o); mem_q.push_back(1'b0);
          exp_q.push_back(idle); mem_q.push_back(1'b0);
        end else if (acked) begin
          exp_q.push_back(idle); mem_q.push_back(1'b0);
        end else begin
          o = idle; o.to = 1'b1; exp_q.push_back(o); mem_q.push_back(1'b0);
        end
      end
    endcase
  endtask

  // Entered and left at #1 after a rising edge with the unit in IDLE.
  task automatic run_instr(input logic [15:0] w, input int k, input string tag);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_handshake: got %b, want 1", tag, instr_ready);
    end
    build_trace(w, k);
    instr_valid = 1'b1;
    instr       = w;
    mem_ack     = 1'($urandom_range(0, 1));
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (obs !== exp_q[c-1]) begin
        n_fail++;
        $display("FAIL %s cycle%0d instr=%h: got %s, want %s",
                 tag, c, w, fmt(obs), fmt(exp_q[c-1]));
      end
      if (c == exp_q.size()) begin
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
      end else begin
        instr_valid = 1'($urandom_range(0, 1));
        instr       = 16'($urandom);
        mem_ack     = mem_q[c-1] ? (c == 2 + k) : 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    obs_t idle;
    idle = '0;
    idle.ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      mem_ack     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_tests++;
      if (obs !== idle) begin
        n_fail++;
        $display("FAIL %s idle%0d: got %s, want %s", tag, i, fmt(obs), fmt(idle));
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    obs_t idle;
    idle = '0;
    idle.ready = 1'b1;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; mem_ack = 1'b0;
    #12;
    n_tests++;
    if (obs !== idle) begin
      n_fail++;
      $display("FAIL reset_values: got %s, want %s", fmt(obs), fmt(idle));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (obs !== idle) begin
      n_fail++;
      $display("FAIL after_reset_idle: got %s, want %s", fmt(obs), fmt(idle));
    end
  endtask

  task automatic test_add();
    run_instr(16'h1A00, 0, "add");
  endtask

  task automatic test_lw();
    run_instr(16'h5300, 3, "lw_ack3");
  endtask

  task automatic test_sw_timeout();
    run_instr(16'h6000, 0, "sw_timeout");
  endtask

  task automatic test_boundary();
    run_instr(16'h5C00, T, "lw_ack_at_limit");
    run_instr(16'h6500, 1, "sw_ack1");
    run_instr(16'h57FF, T + 1, "lw_timeout");
  endtask

  task automatic test_illegal_nop();
    run_instr(16'h8000, 0, "illegal_8");
    run_instr(16'h0000, 0, "nop_after_illegal");
    run_instr(16'hE123, 0, "illegal_E");
  endtask

  task automatic test_back_to_back_random();
    logic [15:0] w;
    int          k;
    for (int i = 0; i < 150; i++) begin
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      k = $urandom_range(0, T + 1);
      run_instr(w, k, $sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), "rand_gap");
    end
  endtask

  task automatic test_async_reset_in_mem();
    obs_t idle;
    idle = '0;
    idle.ready = 1'b1;
    instr_valid = 1'b1; instr = 16'h5700; mem_ack = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
    n_tests++;
    if (mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_read_before_reset: got %b, want 1", mem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== idle) begin
      n_fail++;
      $display("FAIL async_reset_in_mem: got %s, want %s", fmt(obs), fmt(idle));
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (obs !== idle) begin
      n_fail++;
      $display("FAIL idle_after_mem_reset: got %s, want %s", fmt(obs), fmt(idle));
    end
    run_instr(16'h2400, 0, "sub_after_reset");
  endtask

  task automatic test_halt();
    obs_t hexp, idle;
    hexp = '0;
    hexp.halted = 1'b1;
    idle = '0;
    idle.ready = 1'b1;
    run_instr(16'hF000, 0, "halt");
    instr_valid = 1'b1;
    instr       = 16'h1500;
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_tests++;
      if (obs !== hexp) begin
        n_fail++;
        $display("FAIL halt_hold%0d: got %s, want %s", i, fmt(obs), fmt(hexp));
      end
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== idle) begin
      n_fail++;
      $display("FAIL halt_async_reset: got %s, want %s", fmt(obs), fmt(idle));
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(16'h7300, 0, "xor_after_halt_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw_timeout();
    test_boundary();
    test_illegal_nop();
    test_back_to_back_random();
    test_async_reset_in_mem();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
